sipo_rx_ctrl: RTL and testbench

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

---
 rtl/sipo_rx_ctrl.sv | 98 +++++++++
 tb/tb_sipo_rx_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: UART-style receive controller driving a companion 10-bit SIPO shift register.
// Ports: clk, rst (sync, active-low); si serial line; baud_tick oversample strobe;
// po = frame bits 8:1 from the shift register; sr_shift = its shift enable;
// rx_data/rx_valid/rx_ready byte handshake; frame_err/overrun one-cycle pulses; busy = not idle.
module sipo_rx_ctrl #(
  parameter int BIT_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       si,
  input  logic       baud_tick,
  input  logic [7:0] po,
  output logic       sr_shift,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int TW = $clog2(BIT_TICKS);
  localparam logic [TW-1:0] MID  = TW'(BIT_TICKS / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(BIT_TICKS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CAPTURE} state_t;
  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [3:0]    bit_q;
  logic          stop_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;
  // Shift on every sample point the shift register must see: valid start, each data bit, stop.
  assign sr_shift = rst && baud_tick &&
                    (state_q == START ? (tick_q == MID && !si)
                                      : ((state_q == DATA || state_q == STOP) && tick_q == LAST));
  assign busy      = rst && state_q != IDLE;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // Handshake clears first; a successful capture below overrides it in the same cycle.
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (baud_tick && !si) begin
          state_q <= START;
          tick_q  <= '0;
        end
        START: if (baud_tick) begin
          if (tick_q == MID) begin
            if (si) state_q <= IDLE;
            else begin
              state_q <= DATA;
              tick_q  <= '0;
              bit_q   <= '0;
            end
          end else tick_q <= tick_q + TW'(1);
        end
        DATA: if (baud_tick) begin
          if (tick_q == LAST) begin
            tick_q <= '0;
            bit_q  <= bit_q + 4'd1;
            if (bit_q == 4'd7) state_q <= STOP;
          end else tick_q <= tick_q + TW'(1);
        end
        STOP: if (baud_tick) begin
          if (tick_q == LAST) begin
            stop_q  <= si;
            tick_q  <= '0;
            state_q <= CAPTURE;
          end else tick_q <= tick_q + TW'(1);
        end
        CAPTURE: begin
          state_q <= IDLE;
          if (!stop_q) frame_err_q <= 1'b1;
          else if (!rx_valid_q || rx_ready) begin
            rx_data_q  <= po;
            rx_valid_q <= 1'b1;
          end else overrun_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb_sipo_rx_ctrl: directed and randomized frames against a frame-level receive model.
module tb_sipo_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       si = 1'b1;
  logic       baud_tick = 1'b1;
  logic [7:0] po;
  logic       sr_shift;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [9:0] sr = '0;
  int total = 0;
  int bad = 0;
  int n_shift = 0;
  int n_err = 0;
  int n_ov = 0;
  int n_both = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  sipo_rx_ctrl #(.BIT_TICKS(4)) dut (
    .clk(clk), .rst(rst), .si(si), .baud_tick(baud_tick), .po(po),
    .sr_shift(sr_shift), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Companion shift register: first bit in ends at bit 9, so bits 8:1 hold the data MSB-first.
  always @(posedge clk) if (sr_shift) sr <= {sr[8:0], si};
  assign po = sr[8:1];

  always @(negedge clk) begin
    if (sr_shift) n_shift++;
    if (frame_err) n_err++;
    if (overrun) n_ov++;
    if (frame_err && overrun) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tk(input int gap);
    baud_tick = 1'b0;
    cyc(gap);
    baud_tick = 1'b1;
    cyc(1);
  endtask

  // Drives one frame, 4 ticks per bit; lim stops after that many ticks; cap pulses rx_ready in CAPTURE.
  task automatic send(input logic [7:0] d, input logic s, input bit cap, input int gap, input int lim);
    logic [9:0] f;
    int n;
    f = {1'b0, d, s};
    n = 0;
    for (int i = 9; i >= 0; i--)
      for (int k = 0; k < 4; k++) begin
        if (n == lim) return;
        si = f[i];
        tk(gap > 0 ? int'($urandom_range(0, gap)) : 0);
        n++;
        if (i == 0 && k == 2 && cap) begin
          rx_ready = 1'b1;
          baud_tick = 1'b0;
          cyc(1);
          rx_ready = 1'b0;
        end
      end
    si = 1'b1;
    baud_tick = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic s, input bit cap, input int gap);
    int s0, e0, o0, b0, ee, eo;
    s0 = n_shift; e0 = n_err; o0 = n_ov; b0 = n_both;
    ee = 0; eo = 0;
    if (!s) ee = 1;
    else if (m_valid && !cap) eo = 1;
    else begin m_data = d; m_valid = 1'b1; end
    send(d, s, cap, gap, 40);
    cyc(3);
    chk({tag, ".shifts"}, n_shift - s0, 10);
    chk({tag, ".ferr"}, n_err - e0, ee);
    chk({tag, ".ovr"}, n_ov - o0, eo);
    chk({tag, ".both"}, n_both - b0, 0);
    chk({tag, ".data"}, rx_data, m_data);
    chk({tag, ".valid"}, rx_valid, m_valid);
    chk({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    int s0, e0, o0;
    logic [7:0] d;
    cyc(2);
    si = 1'b0;
    cyc(1);
    chk("rst.busy", busy, 0);
    chk("rst.shift", sr_shift, 0);
    chk("rst.valid", rx_valid, 0);
    chk("rst.data", rx_data, 8'h00);
    chk("rst.ferr", frame_err, 0);
    chk("rst.ovr", overrun, 0);
    si = 1'b1;
    rst = 1'b1;
    cyc(2);
    frame("f3c_badstop", 8'h3C, 1'b0, 1'b0, 0);
    frame("fa5", 8'hA5, 1'b1, 1'b0, 0);
    cyc(5);
    chk("fa5.hold", rx_valid, 1);
    consume();
    chk("consume.valid", rx_valid, 0);
    chk("consume.data", rx_data, 8'hA5);
    s0 = n_shift;
    si = 1'b0;
    tk(0);
    chk("false.busy_hi", busy, 1);
    si = 1'b1;
    tk(0); tk(0); tk(0);
    chk("false.busy_lo", busy, 0);
    chk("false.shifts", n_shift - s0, 0);
    chk("false.valid", rx_valid, 0);
    frame("ov1", 8'h3C, 1'b1, 1'b0, 0);
    frame("ov2", 8'hC3, 1'b1, 1'b0, 0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    m_valid = 1'b0;
    chk("ov.clear", rx_valid, 0);
    frame("cap1", 8'h3C, 1'b1, 1'b0, 0);
    frame("cap2", 8'hC3, 1'b1, 1'b1, 0);
    consume();
    e0 = n_err; o0 = n_ov;
    send(8'h5A, 1'b1, 1'b0, 0, 18);
    rst = 1'b0;
    cyc(1);
    chk("midrst.busy", busy, 0);
    chk("midrst.shift", sr_shift, 0);
    m_valid = 1'b0;
    m_data = 8'h00;
    rst = 1'b1;
    si = 1'b1;
    cyc(3);
    chk("midrst.ferr", n_err - e0, 0);
    chk("midrst.ovr", n_ov - o0, 0);
    chk("midrst.valid", rx_valid, 0);
    frame("f81", 8'h81, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) consume();
      d = 8'($urandom);
      frame($sformatf("rnd%0d", i), d, $urandom_range(0, 3) != 0, 1'b0, 2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
